// File: rtl/rx78_pkg.sv
// Shared definitions for the VRAM arbiter.
//   PLANES_DEF / AW_DEF : default plane count and plane address width
//   gnt_e               : which requester owns the RAM port this cycle
//   clr_state_e         : clear engine states
package rx78_pkg;

    localparam int PLANES_DEF = 6;
    localparam int AW_DEF     = 13;

    typedef enum logic [1:0] {NONE, CPU, VDP, CLR} gnt_e;

    typedef enum logic {IDLE, CLEAR} clr_state_e;

endpackage

// File: rtl/vram_bank_dec.sv
// Read-plane decoder: rd_bank value k (1..PLANES) selects plane k-1.
// Any other value selects no plane (all-zero output).
//   bank_i : 8-bit read plane select
//   sel_o  : PLANES-bit one-hot (or zero) plane enable
module vram_bank_dec
    import rx78_pkg::*;
#(
    parameter int PLANES = PLANES_DEF
) (
    input  logic [7:0]        bank_i,
    output logic [PLANES-1:0] sel_o
);

    for (genvar i = 0; i < PLANES; i++) begin : g_dec
        assign sel_o[i] = (bank_i == 8'(i + 1));
    end

endmodule

// File: rtl/vram_arb.sv
// VRAM port arbiter for PLANES byte-wide planes sharing one address bus.
// Fixed priority VDP > clear engine > CPU, one RAM access per cycle.
// A grant drives ram_* combinationally in its cycle; the requester's ack
// (and read data taken from ram_q) appears the following cycle.
//   clk, reset        : clock, synchronous active-high reset
//   cpu_*             : CPU read/write port (level request, 1-cycle ack)
//   rd_bank / wr_bank : CPU read plane select / write plane mask
//   vdp_*             : video fetch of all planes at one address
//   clr_start/busy    : whole-VRAM zero fill
//   ram_*             : shared plane RAM interface (1-cycle read latency)
module vram_arb
    import rx78_pkg::*;
#(
    parameter int PLANES = PLANES_DEF,
    parameter int AW     = AW_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [AW-1:0]       cpu_addr,
    input  logic [7:0]          cpu_din,
    input  logic [7:0]          rd_bank,
    input  logic [7:0]          wr_bank,
    output logic                cpu_ack,
    output logic [7:0]          cpu_q,
    input  logic                vdp_req,
    input  logic [AW-1:0]       vdp_addr,
    output logic                vdp_ack,
    output logic [8*PLANES-1:0] vdp_q,
    input  logic                clr_start,
    output logic                clr_busy,
    output logic [AW-1:0]       ram_addr,
    output logic [7:0]          ram_din,
    output logic [PLANES-1:0]   ram_ce,
    output logic [PLANES-1:0]   ram_we,
    input  logic [8*PLANES-1:0] ram_q
);

    gnt_e                gnt;
    clr_state_e          state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [AW-1:0]       addr_q;
    logic [7:0]          din_q;
    logic                cpu_ack_q, vdp_ack_q, cpu_rd_q;
    logic [PLANES-1:0]   rd_sel, rd_sel_q;
    logic [7:0]          cpu_q_q, rd_byte;
    logic [8*PLANES-1:0] vdp_q_q;

    vram_bank_dec #(.PLANES(PLANES)) u_bank_dec (
        .bank_i (rd_bank),
        .sel_o  (rd_sel)
    );

    if (PLANES < 8) begin : g_unused
        logic unused_wr_bank;
        assign unused_wr_bank = ^wr_bank[7:PLANES];
    end

    // A requester whose ack is showing is not eligible, which caps each at
    // one access every two cycles and lets a level request drop on its ack.
    // The CPU is only served while the clear engine is idle.
    always_comb begin
        gnt = NONE;
        if (!reset) begin
            if (vdp_req && !vdp_ack_q)      gnt = VDP;
            else if (state_q == CLEAR)      gnt = CLR;
            else if (cpu_req && !cpu_ack_q) gnt = CPU;
        end
    end

    // Clear engine: the counter only advances on cycles it actually owns the
    // port, so VDP pre-emption never skips an address. A new clr_start
    // always restarts from zero, even mid-clear.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (gnt == CLR) begin
            cnt_d = cnt_q + AW'(1);
            if (&cnt_q) state_d = IDLE;
        end
        if (clr_start) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end
    end

    // With no grant the address/data buses keep their last driven value.
    always_comb begin
        ram_ce   = '0;
        ram_we   = '0;
        ram_addr = addr_q;
        ram_din  = din_q;
        case (gnt)
            VDP: begin
                ram_ce   = '1;
                ram_addr = vdp_addr;
            end
            CLR: begin
                ram_ce   = '1;
                ram_we   = '1;
                ram_addr = cnt_q;
                ram_din  = 8'h00;
            end
            CPU: begin
                ram_addr = cpu_addr;
                ram_din  = cpu_din;
                if (cpu_we) begin
                    ram_ce = wr_bank[PLANES-1:0];
                    ram_we = wr_bank[PLANES-1:0];
                end else begin
                    ram_ce = rd_sel;
                end
            end
            default: ;
        endcase
    end

    // Plane byte for the CPU read; zero when no plane was selected.
    always_comb begin
        rd_byte = 8'h00;
        for (int i = 0; i < PLANES; i++)
            if (rd_sel_q[i]) rd_byte = rd_byte | ram_q[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            cpu_ack_q <= 1'b0;
            vdp_ack_q <= 1'b0;
            cpu_rd_q  <= 1'b0;
            rd_sel_q  <= '0;
            cpu_q_q   <= '0;
            vdp_q_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cpu_ack_q <= (gnt == CPU);
            vdp_ack_q <= (gnt == VDP);
            if (gnt != NONE) begin
                addr_q <= ram_addr;
                din_q  <= ram_din;
            end
            if (gnt == CPU) begin
                cpu_rd_q <= !cpu_we;
                rd_sel_q <= rd_sel;
            end
            if (cpu_ack_q && cpu_rd_q) cpu_q_q <= rd_byte;
            if (vdp_ack_q)             vdp_q_q <= ram_q;
        end
    end

    // Read data is live from ram_q during the ack and held afterwards.
    assign cpu_ack  = cpu_ack_q;
    assign vdp_ack  = vdp_ack_q;
    assign cpu_q    = (cpu_ack_q && cpu_rd_q) ? rd_byte : cpu_q_q;
    assign vdp_q    = vdp_ack_q ? ram_q : vdp_q_q;
    assign clr_busy = (state_q == CLEAR);

endmodule

// File: tb/tb_vram_arb.sv
module tb_vram_arb;

    localparam int PLANES = 6;
    localparam int AW     = 13;
    localparam int DEPTH  = 1 << AW;

    logic                clk, reset;
    logic                cpu_req, cpu_we;
    logic [AW-1:0]       cpu_addr;
    logic [7:0]          cpu_din, rd_bank, wr_bank;
    logic                cpu_ack;
    logic [7:0]          cpu_q;
    logic                vdp_req;
    logic [AW-1:0]       vdp_addr;
    logic                vdp_ack;
    logic [8*PLANES-1:0] vdp_q;
    logic                clr_start, clr_busy;
    logic [AW-1:0]       ram_addr;
    logic [7:0]          ram_din;
    logic [PLANES-1:0]   ram_ce, ram_we;
    logic [8*PLANES-1:0] ram_q;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] ram_mem [PLANES][DEPTH];
    logic [7:0] refm    [PLANES][DEPTH];

    vram_arb #(.PLANES(PLANES), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .rd_bank(rd_bank), .wr_bank(wr_bank), .cpu_ack(cpu_ack), .cpu_q(cpu_q),
        .vdp_req(vdp_req), .vdp_addr(vdp_addr), .vdp_ack(vdp_ack), .vdp_q(vdp_q),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_ce(ram_ce), .ram_we(ram_we),
        .ram_q(ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plane RAMs: synchronous, one-cycle read latency, output holds when idle.
    always @(posedge clk) begin
        for (int p = 0; p < PLANES; p++) begin
            if (ram_ce[p]) begin
                if (ram_we[p]) ram_mem[p][ram_addr] <= ram_din;
                else           ram_q[8*p +: 8]      <= ram_mem[p][ram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_c(input logic [AW-1:0] a, input logic [7:0] rb);
        if (rb >= 8'd1 && rb <= 8'd6) return refm[rb-8'd1][a];
        return 8'h00;
    endfunction

    function automatic logic [8*PLANES-1:0] exp_v(input logic [AW-1:0] a);
        logic [8*PLANES-1:0] r;
        for (int p = 0; p < PLANES; p++) r[8*p +: 8] = refm[p][a];
        return r;
    endfunction

    function automatic logic [PLANES-1:0] exp_sel(input logic [7:0] rb);
        logic [PLANES-1:0] s;
        s = '0;
        if (rb >= 8'd1 && rb <= 8'd6) s[rb-8'd1] = 1'b1;
        return s;
    endfunction

    // Full clear, optionally with periodic VDP fetches, a held CPU read, or a
    // restart pulse issued right after address rs_at is written.
    task automatic do_clear(input int vper, input int rs_at, input bit hold_cpu);
        int exp_a, wr, vg, busy, bad, cyc, cpu_in_busy, extra, last_a, n;
        bit rs_done, got;
        exp_a = 0; wr = 0; vg = 0; busy = 0; bad = 0; cyc = 0;
        cpu_in_busy = 0; extra = 0; last_a = -1; rs_done = 0;
        step(); clr_start = 1'b1;
        @(negedge clk);
        chk("clr_busy_start_cycle", clr_busy, 0);
        step(); clr_start = 1'b0;
        if (hold_cpu) begin
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'd5; rd_bank = 8'd1;
        end
        while (cyc < 20000) begin
            @(negedge clk);
            if (!clr_busy) break;
            busy++;
            if (cpu_ack) cpu_in_busy++;
            if (ram_we != '0) begin
                if (ram_we != '1 || ram_ce != '1 || ram_addr != AW'(exp_a) || ram_din != 8'h00) bad++;
                last_a = int'(ram_addr);
                wr++;
                exp_a++;
            end else if (ram_ce == '1) vg++;
            else bad++;
            if (clr_start) exp_a = 0;
            step();
            clr_start = 1'b0;
            vdp_req   = (vper != 0) && (cyc % vper == 0);
            vdp_addr  = AW'($urandom);
            if (rs_at >= 0 && !rs_done && wr == rs_at + 1) begin
                clr_start = 1'b1; rs_done = 1'b1; extra = rs_at + 2;
            end
            cyc++;
        end
        chk("clr_timeout", cyc < 20000, 1);
        chk("clr_writes", wr, DEPTH + extra);
        chk("clr_bad_cycles", bad, 0);
        chk("clr_last_addr", last_a, DEPTH - 1);
        chk("clr_busy_len", busy, DEPTH + extra + vg);
        if (vper != 0) chk("clr_vdp_seen", vg > 0, 1);
        step(); vdp_req = 1'b0;
        if (hold_cpu) begin
            n = 0; got = 0;
            while (n < 4 && !got) begin
                @(negedge clk);
                if (cpu_ack) begin
                    got = 1;
                    chk("clr_cpu_q", cpu_q, 8'h00);
                end else begin
                    step(); n++;
                end
            end
            chk("clr_cpu_ack", got, 1);
            chk("clr_cpu_in_busy", cpu_in_busy, 0);
            step(); cpu_req = 1'b0;
        end
    endtask

    task automatic do_cpu(input bit we, input logic [AW-1:0] a, input logic [7:0] d,
                          input logic [7:0] rb, input logic [7:0] wb);
        int lat, wec;
        logic [PLANES-1:0] gce, gwe;
        logic [AW-1:0] ga;
        step();
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d; rd_bank = rb; wr_bank = wb;
        lat = 0; wec = 0; gce = '0; gwe = '0; ga = '0;
        while (lat < 20) begin
            @(negedge clk);
            if (cpu_ack) break;
            if (lat == 0) begin gce = ram_ce; gwe = ram_we; ga = ram_addr; end
            if (ram_we != '0) wec++;
            step(); lat++;
        end
        chk("cpu_latency", lat, 1);
        chk("cpu_addr_bus", ga, a);
        if (we) begin
            chk("cpu_wr_we", gwe, wb[PLANES-1:0]);
            chk("cpu_wr_ce", gce, wb[PLANES-1:0]);
            chk("cpu_wr_cycles", wec, (wb[PLANES-1:0] != '0) ? 1 : 0);
            for (int p = 0; p < PLANES; p++) if (wb[p]) refm[p][a] = d;
        end else begin
            chk("cpu_rd_q", cpu_q, exp_c(a, rb));
            chk("cpu_rd_ce", gce, exp_sel(rb));
            chk("cpu_rd_we", gwe, 0);
        end
        step(); cpu_req = 1'b0;
    endtask

    task automatic do_vdp(input logic [AW-1:0] a);
        step(); vdp_req = 1'b1; vdp_addr = a;
        @(negedge clk);
        chk("vdp_grant_ce", ram_ce, 6'h3F);
        chk("vdp_grant_we", ram_we, 0);
        chk("vdp_ack_early", vdp_ack, 0);
        step(); vdp_req = 1'b0;
        @(negedge clk);
        chk("vdp_ack", vdp_ack, 1);
        chk("vdp_q", vdp_q, exp_v(a));
    endtask

    task automatic dual(input logic [AW-1:0] ca, input logic [7:0] rb, input logic [AW-1:0] va);
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ca; rd_bank = rb;
        vdp_req = 1'b1; vdp_addr = va;
        @(negedge clk);
        chk("dual_n_ce", ram_ce, 6'h3F);
        chk("dual_n_addr", ram_addr, va);
        step(); vdp_req = 1'b0;
        @(negedge clk);
        chk("dual_vdp_ack", vdp_ack, 1);
        chk("dual_vdp_q", vdp_q, exp_v(va));
        chk("dual_cpu_ack_n1", cpu_ack, 0);
        chk("dual_n1_ce", ram_ce, exp_sel(rb));
        step();
        @(negedge clk);
        chk("dual_cpu_ack_n2", cpu_ack, 1);
        chk("dual_cpu_q", cpu_q, exp_c(ca, rb));
        step(); cpu_req = 1'b0;
    endtask

    initial begin
        int n;
        bit hit;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        rd_bank = '0; wr_bank = '0; vdp_req = 1'b0; vdp_addr = '0; clr_start = 1'b0;
        for (int p = 0; p < PLANES; p++)
            for (int a = 0; a < DEPTH; a++) refm[p][a] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_vdp_ack", vdp_ack, 0);
        chk("rst_cpu_q", cpu_q, 0);
        chk("rst_vdp_q", vdp_q, 0);
        chk("rst_clr_busy", clr_busy, 0);
        chk("rst_ram_ce", ram_ce, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_din", ram_din, 0);

        // A request arriving while reset is held must never be acked.
        step(); cpu_req = 1'b1; rd_bank = 8'd1;
        @(negedge clk);
        step(); reset = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        chk("rst_req_no_ack", cpu_ack, 0);

        do_clear(0, -1, 1'b0);
        do_clear(8, -1, 1'b1);
        do_clear(0, 16, 1'b0);

        do_cpu(1'b1, 13'h0100, 8'h5A, 8'd0, 8'h05);
        do_cpu(1'b0, 13'h0100, 8'h00, 8'd3, 8'h00);
        do_cpu(1'b0, 13'h0100, 8'h00, 8'd2, 8'h00);
        do_cpu(1'b0, 13'h0100, 8'h00, 8'h07, 8'h00);
        do_cpu(1'b1, 13'h0101, 8'h33, 8'd0, 8'hC0);
        do_vdp(13'h0100);
        dual(13'h0100, 8'd3, 13'h0100);

        for (int i = 0; i < 150; i++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, 31)) | 13'h0100;
            case ($urandom_range(0, 3))
                0: do_cpu(1'b1, a, 8'($urandom), 8'd0, 8'($urandom));
                1: do_cpu(1'b0, a, 8'h00, 8'($urandom_range(0, 8)), 8'h00);
                2: do_vdp(a);
                default: dual(a, 8'($urandom_range(0, 8)), AW'($urandom_range(0, 31)) | 13'h0100);
            endcase
        end

        // Reset in the middle of a clear abandons it; a new clear starts at 0.
        step(); clr_start = 1'b1;
        step(); clr_start = 1'b0;
        n = 0; hit = 0;
        while (n < 5000 && !hit) begin
            @(negedge clk);
            if (ram_we != '0 && ram_addr == 13'h0800) hit = 1;
            else begin step(); n++; end
        end
        chk("rstclr_reached_800", hit, 1);
        step(); reset = 1'b1;
        @(negedge clk);
        chk("rstclr_we_off", ram_we, 0);
        step(); reset = 1'b0;
        @(negedge clk);
        chk("rstclr_busy", clr_busy, 0);
        chk("rstclr_ram_addr", ram_addr, 0);
        do_clear(0, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/vram_arb.md
VRAM_ARB -- requirements
Module: vram_arb

Interface
REQ-001 SHALL have parameters: PLANES, default 6, number of VRAM planes; AW, default 13, plane address width.
REQ-002 SHALL have ports, in this order:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  AW  plane offset
- cpu_din  in  8  write data
- rd_bank  in  8  read plane select; 1..6 valid, other values select no plane
- wr_bank  in  8  write plane mask, bit i = plane i
- cpu_ack  out  1  one-cycle completion pulse
- cpu_q  out  8  read data, valid with cpu_ack
- vdp_req  in  1  video fetch request, level
- vdp_addr  in  AW  fetch address
- vdp_ack  out  1  one-cycle completion pulse
- vdp_q  out  8*PLANES  all plane bytes, valid with vdp_ack
- clr_start  in  1  one-cycle clear command
- clr_busy  out  1  clear in progress
- ram_addr  out  AW  shared plane address
- ram_din  out  8  shared write data
- ram_ce  out  PLANES  per-plane enable, active-high
- ram_we  out  PLANES  per-plane write, active-high
- ram_q  in  8*PLANES  plane read data, 1-cycle latency
REQ-003 SHALL state: reset reset, synchronous, active-high; clock clk.

Function
REQ-004 SHALL issue at most one RAM access per cycle; fixed priority VDP > clear > CPU.
REQ-005 SHALL not grant a requester in the cycle its ack is asserted; max rate one access per requester every 2 cycles.
REQ-006 A request granted in cycle N SHALL drive ram_* in N and assert ack in N+1 with data registered from ram_q.
REQ-007 CPU read SHALL enable only the plane decoded from rd_bank; cpu_q = that plane's byte, 0x00 if rd_bank selects no plane.
REQ-008 CPU write SHALL assert ram_ce and ram_we for every plane with wr_bank[i]=1 simultaneously; wr_bank[5:0]=0 SHALL still ack, with no write.
REQ-009 VDP grant SHALL enable all planes for read; vdp_q[8i+7:8i] = plane i.
REQ-010 Clear FSM states: IDLE, CLEAR. IDLE->CLEAR on clr_start, counter=0. CLEAR: each granted cycle writes 0x00 to all planes at counter, then counter+1. CLEAR->IDLE after address 2^AW-1 is written.
REQ-011 clr_busy SHALL be high in CLEAR and fall the cycle after the last write.
REQ-012 clr_start in CLEAR SHALL restart counter at 0 with no extra idle cycle.
REQ-013 VDP requests during CLEAR SHALL pre-empt the clear; the counter holds and no address is skipped.
REQ-014 CPU requests during CLEAR SHALL wait until IDLE; cpu_ack stays low.
REQ-015 Simultaneous cpu_req and vdp_req: VDP SHALL be granted in N, CPU in N+1 unless vdp_req is re-granted.
REQ-016 With no grant, ram_ce = ram_we = 0, and ram_addr and ram_din hold their previous values.
REQ-017 Counter arithmetic SHALL be AW bits; no wrap past 2^AW-1 within one clear.

Reset
REQ-018 On reset: cpu_ack=0, vdp_ack=0, cpu_q=0, vdp_q=0, clr_busy=0, FSM=IDLE, counter=0, ram_ce=ram_we=0, ram_addr=0, ram_din=0.
REQ-019 Reset mid-access SHALL drop the pending ack; reset mid-clear SHALL abandon the clear without completing it.

Structure
REQ-020 Shared package rx78_pkg SHALL hold the PLANES and AW defaults, the grant enum (NONE, CPU, VDP, CLR) and the clear-state enum.
REQ-021 Bank decode SHALL be one sub-module, vram_bank_dec: 8-bit rd_bank to PLANES-bit one-hot.

Verification
REQ-022 CPU write addr 0x0100, din 0x5A, wr_bank 0x05 -> ram_we=0b000101 for one cycle, cpu_ack next cycle; a read with rd_bank 3 returns 0x5A, with rd_bank 2 returns 0x00.
REQ-023 cpu_req and vdp_req both rise in cycle N -> vdp_ack N+1, cpu_ack N+2.
REQ-024 clr_start, no other traffic -> 8192 writes of 0x00 to 0x0000..0x1FFF with ram_we=0x3F; clr_busy high for exactly 8192 cycles.
REQ-025 Clear with vdp_req pulsed every 8 cycles -> no address skipped or repeated; clr_busy length = 8192 + VDP grant count.
REQ-026 CPU read with rd_bank 0x07 -> cpu_ack one cycle after grant, cpu_q=0x00, exactly one plane-free access.
REQ-027 Reset asserted at clear address 0x0800 -> clr_busy=0 next cycle; a new clr_start restarts from 0x0000.
